// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the cache-control path
//
// Purpose: word and RAM handshake types used across the memory path, plus the
// memory arbiter's FSM state and request-kind enums.
// Ports: none (package).

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } memarb_state_t;

  // Encoding order doubles as intra-CPU priority: lower value wins.
  typedef enum logic [1:0] {
    KIND_DWEN = 2'd0,
    KIND_DREN = 2'd1,
    KIND_IREN = 2'd2
  } req_kind_t;

endpackage

// File: rtl/memarb_pick.sv
// rtl/memarb_pick.sv - round-robin winner and request-kind priority encoder
//
// Purpose: chooses which CPU and which access kind the arbiter serves next.
// Ports:
//   iren, dren, dwen : per-CPU request bits (bit 1 is CPU 1)
//   rr_ptr           : CPU that has priority this round
//   valid            : at least one request pending
//   cpu              : winning CPU
//   kind             : winning access kind (dWEN > dREN > iREN)

module memarb_pick
  import cpu_types_pkg::*;
(
  input  logic [1:0] iren,
  input  logic [1:0] dren,
  input  logic [1:0] dwen,
  input  logic       rr_ptr,
  output logic       valid,
  output logic       cpu,
  output req_kind_t  kind
);

  logic [1:0] any_req;

  assign any_req = iren | dren | dwen;

  always_comb begin
    valid = |any_req;
    // Favoured CPU wins if it asks at all; otherwise fall through to the other.
    cpu   = any_req[rr_ptr] ? rr_ptr : ~rr_ptr;
    if (dwen[cpu]) begin
      kind = KIND_DWEN;
    end else if (dren[cpu]) begin
      kind = KIND_DREN;
    end else begin
      kind = KIND_IREN;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-CPU round-robin arbiter for the single RAM port
//
// Purpose: serialises instruction fetches, data reads and data writes from up
// to two CPUs onto one RAM port, with per-cache wait/load handshakes.
// Optional snoop outputs are built when MEM_ARBITER_SNOOP_EN is defined;
// otherwise ccwait/ccinv/ccsnoopaddr are tied to 0.
// Ports:
//   CLK, RST                  : clock, synchronous active-high reset
//   iREN, dREN, dWEN          : per-CPU request bits
//   iaddr, daddr, dstore      : per-CPU address/data words (CPU n at word n)
//   ccwrite                   : per-CPU exclusive-write intent
//   iwait, dwait              : per-CPU waits, low only in the completion cycle
//   iload, dload              : per-CPU return data, 0 unless completing
//   ramREN, ramWEN            : RAM enables
//   ramaddr, ramstore         : registered RAM address / write data
//   ramload, ramstate         : RAM return data and handshake state
//   ccwait, ccinv, ccsnoopaddr: coherence snoop outputs

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = $bits(word_t)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr
);

  // Internal logic always works on two CPU slots; with CPUS=1 slot 1 is
  // tied idle on the way in and dropped on the way out.
  logic [1:0]          iren2, dren2, dwen2, ccwrite2;
  logic [2*WORD_W-1:0] iaddr2, daddr2, dstore2;
  logic [1:0]          iwait2, dwait2, ccwait2, ccinv2;
  logic [2*WORD_W-1:0] iload2, dload2, ccsnoop2;

  generate
    if (CPUS == 2) begin : g_two
      assign iren2    = iREN;
      assign dren2    = dREN;
      assign dwen2    = dWEN;
      assign ccwrite2 = ccwrite;
      assign iaddr2   = iaddr;
      assign daddr2   = daddr;
      assign dstore2  = dstore;
    end else begin : g_one
      assign iren2    = {1'b0, iREN[0]};
      assign dren2    = {1'b0, dREN[0]};
      assign dwen2    = {1'b0, dWEN[0]};
      assign ccwrite2 = {1'b0, ccwrite[0]};
      assign iaddr2   = {{WORD_W{1'b0}}, iaddr[WORD_W-1:0]};
      assign daddr2   = {{WORD_W{1'b0}}, daddr[WORD_W-1:0]};
      assign dstore2  = {{WORD_W{1'b0}}, dstore[WORD_W-1:0]};
    end
  endgenerate

  assign iwait       = iwait2[CPUS-1:0];
  assign dwait       = dwait2[CPUS-1:0];
  assign iload       = iload2[CPUS*WORD_W-1:0];
  assign dload       = dload2[CPUS*WORD_W-1:0];
  assign ccwait      = ccwait2[CPUS-1:0];
  assign ccinv       = ccinv2[CPUS-1:0];
  assign ccsnoopaddr = ccsnoop2[CPUS*WORD_W-1:0];

  function automatic logic [WORD_W-1:0] word_sel(input logic [2*WORD_W-1:0] v,
                                                 input logic sel);
    return sel ? v[2*WORD_W-1:WORD_W] : v[WORD_W-1:0];
  endfunction

  memarb_state_t       state, next_state;
  logic                rr_ptr;
  logic                win_cpu;
  req_kind_t           win_kind;
  logic [WORD_W-1:0]   ramaddr_q, ramstore_q;

  logic                pick_valid, pick_cpu;
  req_kind_t           pick_kind;
  logic                req_live, active, done;

  memarb_pick u_pick (
    .iren   (iren2),
    .dren   (dren2),
    .dwen   (dwen2),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .cpu    (pick_cpu),
    .kind   (pick_kind)
  );

  // The granted request bit; if the requester lets go, the access aborts.
  always_comb begin
    case (win_kind)
      KIND_DWEN: req_live = dwen2[win_cpu];
      KIND_DREN: req_live = dren2[win_cpu];
      default:   req_live = iren2[win_cpu];
    endcase
  end

  // RST gates the combinational outputs so a reset cycle never completes.
  assign active = (state == REQ) && req_live && !RST;
  assign done   = active && (ramstate == ACCESS);

  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      win_cpu    <= 1'b0;
      win_kind   <= KIND_DWEN;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && pick_valid) begin
        win_cpu    <= pick_cpu;
        win_kind   <= pick_kind;
        ramaddr_q  <= (pick_kind == KIND_IREN) ? word_sel(iaddr2, pick_cpu)
                                               : word_sel(daddr2, pick_cpu);
        ramstore_q <= word_sel(dstore2, pick_cpu);
      end
      if (done) begin
        rr_ptr <= ~win_cpu;
      end
    end
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    iwait2     = '1;
    dwait2     = '1;
    iload2     = '0;
    dload2     = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          next_state = REQ;
        end
      end
      REQ: begin
        // ERROR/BUSY/FREE all hold in REQ with the enable still up.
        if (!req_live || ramstate == ACCESS) begin
          next_state = IDLE;
        end
        if (active) begin
          if (win_kind == KIND_DWEN) begin
            ramWEN = 1'b1;
          end else begin
            ramREN = 1'b1;
          end
        end
        if (done) begin
          if (win_kind == KIND_IREN) begin
            iwait2[win_cpu] = 1'b0;
            if (win_cpu) iload2[2*WORD_W-1:WORD_W] = ramload;
            else         iload2[WORD_W-1:0]        = ramload;
          end else begin
            dwait2[win_cpu] = 1'b0;
            if (win_kind == KIND_DREN) begin
              if (win_cpu) dload2[2*WORD_W-1:WORD_W] = ramload;
              else         dload2[WORD_W-1:0]        = ramload;
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef MEM_ARBITER_SNOOP_EN
  // Data accesses by one CPU snoop the other CPU's cache.
  always_comb begin
    ccwait2  = '0;
    ccinv2   = '0;
    ccsnoop2 = '0;
    if (active && win_kind != KIND_IREN) begin
      ccwait2[~win_cpu] = 1'b1;
      if (win_cpu) ccsnoop2[WORD_W-1:0]        = ramaddr_q;
      else         ccsnoop2[2*WORD_W-1:WORD_W] = ramaddr_q;
      if (done) begin
        ccinv2[~win_cpu] = ccwrite2[win_cpu] || (win_kind == KIND_DWEN);
      end
    end
  end
`else
  assign ccwait2  = '0;
  assign ccinv2   = '0;
  assign ccsnoop2 = '0;
  logic unused_ccwrite;
  assign unused_ccwrite = ^ccwrite2;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN, ccwrite;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait, ccwait, ccinv;
  logic [63:0] iload, dload, ccsnoopaddr;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int checks = 0;
  int failures = 0;

  // Reference model state: outstanding requests per CPU and round-robin owner.
  bit          pi [2];
  bit          pdr [2];
  bit          pdw [2];
  logic [31:0] ia [2];
  logic [31:0] da [2];
  logic [31:0] ds [2];
  int          rr;

  always #5 CLK = ~CLK;

  mem_arbiter #(.CPUS(2), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ccwrite = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = RS_FREE;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    adv();
    adv();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1'b1;
    adv();
    iREN = 2'b11; ramstate = RS_ACCESS;
    #2;
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL reset_iwait got=%b exp=11", iwait); end
    checks++; if (dwait !== 2'b11) begin failures++; $display("FAIL reset_dwait got=%b exp=11", dwait); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL reset_en got=%b exp=00", {ramREN, ramWEN}); end
    checks++; if ({ramaddr, ramstore} !== 64'h0) begin failures++; $display("FAIL reset_ram got=%h exp=0", {ramaddr, ramstore}); end
    checks++; if ({iload, dload} !== 128'h0) begin failures++; $display("FAIL reset_loads got=%h exp=0", {iload, dload}); end
    checks++; if ({ccwait, ccinv, ccsnoopaddr} !== 68'h0) begin failures++; $display("FAIL reset_cc got=%h exp=0", {ccwait, ccinv, ccsnoopaddr}); end
    RST = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_fetch();
    do_reset();
    adv(); iREN = 2'b01; iaddr = 64'h100; ramstate = RS_FREE; #2;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL fetch_idle_ren got=%b exp=0", ramREN); end
    adv(); ramstate = RS_BUSY; #2;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin failures++; $display("FAIL fetch_req got=%b/%h exp=1/100", ramREN, ramaddr); end
    checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL fetch_busy_iwait got=%b exp=11", iwait); end
    adv(); ramstate = RS_ACCESS; ramload = 32'hDEADBEEF; #2;
    checks++; if (iwait !== 2'b10) begin failures++; $display("FAIL fetch_done_iwait got=%b exp=10", iwait); end
    checks++; if (iload !== 64'h00000000DEADBEEF) begin failures++; $display("FAIL fetch_iload got=%h exp=DEADBEEF", iload); end
    adv(); iREN = 2'b00; ramstate = RS_FREE; #2;
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11 || iload !== 64'h0) begin failures++; $display("FAIL fetch_after got=%b/%b/%h exp=0/11/0", ramREN, iwait, iload); end
  endtask

  task automatic test_rr_alternate();
    logic [31:0] ld;
    logic [63:0] exp_ld;
    do_reset();
    adv(); dREN = 2'b11; daddr = {32'h300, 32'h200}; ramstate = RS_FREE; #2;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL rr_idle_ren got=%b exp=0", ramREN); end
    for (int n = 0; n < 4; n++) begin
      ld = $urandom;
      exp_ld = (n % 2 == 1) ? {ld, 32'h0} : {32'h0, ld};
      adv(); ramstate = RS_ACCESS; ramload = ld; #2;
      checks++; if (ramaddr !== ((n % 2 == 1) ? 32'h300 : 32'h200)) begin failures++; $display("FAIL rr_addr n=%0d got=%h", n, ramaddr); end
      checks++; if (dwait !== ((n % 2 == 1) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rr_dwait n=%0d got=%b", n, dwait); end
      checks++; if (dload !== exp_ld) begin failures++; $display("FAIL rr_dload n=%0d got=%h exp=%h", n, dload, exp_ld); end
      adv(); ramstate = RS_FREE; #2;
      checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin failures++; $display("FAIL rr_bubble n=%0d got=%b/%b exp=0/11", n, ramREN, dwait); end
    end
    dREN = 2'b00;
  endtask

  task automatic test_write_then_fetch();
    logic [31:0] ld;
    do_reset();
    adv(); dWEN = 2'b10; iREN = 2'b10; daddr = {32'h40, 32'h0};
    dstore = {32'h12345678, 32'h0}; iaddr = {32'h500, 32'h0}; ramstate = RS_FREE; #2;
    checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL wf_idle_wen got=%b exp=0", ramWEN); end
    adv(); ramstate = RS_ACCESS; #2;
    checks++; if ({ramWEN, ramREN} !== 2'b10) begin failures++; $display("FAIL wf_write_en got=%b exp=10", {ramWEN, ramREN}); end
    checks++; if (ramaddr !== 32'h40 || ramstore !== 32'h12345678) begin failures++; $display("FAIL wf_write_data got=%h/%h exp=40/12345678", ramaddr, ramstore); end
    checks++; if (dwait !== 2'b01 || iwait !== 2'b11) begin failures++; $display("FAIL wf_write_waits got=%b/%b exp=01/11", dwait, iwait); end
`ifdef MEM_ARBITER_SNOOP_EN
    checks++; if (ccwait !== 2'b01 || ccinv !== 2'b01 || ccsnoopaddr !== 64'h40) begin failures++; $display("FAIL wf_snoop got=%b/%b/%h", ccwait, ccinv, ccsnoopaddr); end
`else
    checks++; if ({ccwait, ccinv, ccsnoopaddr} !== 68'h0) begin failures++; $display("FAIL wf_cc_tied got=%h exp=0", {ccwait, ccinv, ccsnoopaddr}); end
`endif
    adv(); dWEN = 2'b00; ramstate = RS_FREE; #2;
    checks++; if ({ramWEN, ramREN} !== 2'b00 || iwait !== 2'b11) begin failures++; $display("FAIL wf_bubble got=%b/%b exp=00/11", {ramWEN, ramREN}, iwait); end
    ld = $urandom;
    adv(); ramstate = RS_ACCESS; ramload = ld; #2;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin failures++; $display("FAIL wf_fetch_req got=%b/%h exp=1/500", ramREN, ramaddr); end
    checks++; if (iwait !== 2'b01 || iload !== {ld, 32'h0}) begin failures++; $display("FAIL wf_fetch_done got=%b/%h exp=01/%h", iwait, iload, {ld, 32'h0}); end
    adv(); iREN = 2'b00; ramstate = RS_FREE;
  endtask

  task automatic test_error_retry();
    logic [31:0] ld;
    do_reset();
    adv(); dREN = 2'b01; daddr = 64'h600; #2;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL err_idle got=%b exp=0", ramREN); end
    for (int n = 0; n < 3; n++) begin
      adv(); ramstate = RS_ERROR; #2;
      checks++; if (ramREN !== 1'b1 || dwait !== 2'b11 || ramaddr !== 32'h600) begin failures++; $display("FAIL err_hold n=%0d got=%b/%b/%h exp=1/11/600", n, ramREN, dwait, ramaddr); end
    end
    ld = $urandom;
    adv(); ramstate = RS_ACCESS; ramload = ld; #2;
    checks++; if (dwait !== 2'b10 || dload !== {32'h0, ld}) begin failures++; $display("FAIL err_done got=%b/%h exp=10/%h", dwait, dload, ld); end
    adv(); dREN = 2'b00; #2;
    checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin failures++; $display("FAIL err_dup1 got=%b/%b exp=0/11", ramREN, dwait); end
    adv(); #2;
    checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin failures++; $display("FAIL err_dup2 got=%b/%b exp=0/11", ramREN, dwait); end
    ramstate = RS_FREE;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ld;
    do_reset();
    adv(); iREN = 2'b01; iaddr = 64'h700; ramstate = RS_FREE;
    adv(); ramstate = RS_BUSY; #2;
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL rmid_req got=%b exp=1", ramREN); end
    adv(); RST = 1'b1;
    adv(); RST = 1'b0; #2;
    checks++; if ({ramREN, ramWEN} !== 2'b00 || iwait !== 2'b11 || dwait !== 2'b11) begin failures++; $display("FAIL rmid_after got=%b/%b/%b", {ramREN, ramWEN}, iwait, dwait); end
    checks++; if (ramaddr !== 32'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", ramaddr); end
    ld = $urandom;
    adv(); ramstate = RS_ACCESS; ramload = ld; #2;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h700 || iwait !== 2'b10 || iload !== {32'h0, ld}) begin failures++; $display("FAIL rmid_reissue got=%b/%h/%b/%h", ramREN, ramaddr, iwait, iload); end
    adv(); iREN = 2'b00; ramstate = RS_FREE;
  endtask

  task automatic test_abort();
    do_reset();
    adv(); iREN = 2'b01; iaddr = 64'h900; ramstate = RS_FREE;
    adv(); ramstate = RS_BUSY; #2;
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL abort_req got=%b exp=1", ramREN); end
    adv(); iREN = 2'b00; ramstate = RS_ACCESS; #2;
    checks++; if (iwait !== 2'b11 || iload !== 64'h0) begin failures++; $display("FAIL abort_nodone got=%b/%h exp=11/0", iwait, iload); end
    adv(); iREN = 2'b11; iaddr = {32'hA00, 32'h900}; ramstate = RS_FREE; #2;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", ramREN); end
    adv(); ramstate = RS_ACCESS; #2;
    checks++; if (ramaddr !== 32'h900 || iwait !== 2'b10) begin failures++; $display("FAIL abort_rr_kept got=%h/%b exp=900/10", ramaddr, iwait); end
    adv(); iREN = 2'b00; ramstate = RS_FREE;
  endtask

  task automatic test_snoop();
    do_reset();
    adv(); dWEN = 2'b01; daddr = 64'h80; dstore = {32'h0, $urandom}; ramstate = RS_FREE; #2;
    checks++; if (ccwait !== 2'b00) begin failures++; $display("FAIL snoop_idle got=%b exp=00", ccwait); end
    adv(); ramstate = RS_BUSY; #2;
`ifdef MEM_ARBITER_SNOOP_EN
    checks++; if (ccwait !== 2'b10 || ccsnoopaddr !== {32'h80, 32'h0} || ccinv !== 2'b00) begin failures++; $display("FAIL snoop_req got=%b/%h/%b", ccwait, ccsnoopaddr, ccinv); end
`else
    checks++; if ({ccwait, ccinv, ccsnoopaddr} !== 68'h0) begin failures++; $display("FAIL snoop_tied got=%h exp=0", {ccwait, ccinv, ccsnoopaddr}); end
`endif
    adv(); ramstate = RS_ACCESS; #2;
    checks++; if (dwait !== 2'b10 || ramWEN !== 1'b1) begin failures++; $display("FAIL snoop_done got=%b/%b exp=10/1", dwait, ramWEN); end
`ifdef MEM_ARBITER_SNOOP_EN
    checks++; if (ccinv !== 2'b10) begin failures++; $display("FAIL snoop_inv got=%b exp=10", ccinv); end
`else
    checks++; if (ccinv !== 2'b00) begin failures++; $display("FAIL snoop_inv_tied got=%b exp=00", ccinv); end
`endif
    adv(); dWEN = 2'b00; ramstate = RS_FREE; #2;
    checks++; if (ccwait !== 2'b00) begin failures++; $display("FAIL snoop_after got=%b exp=00", ccwait); end
  endtask

  task automatic drive_model();
    iREN  = {pi[1], pi[0]};
    dREN  = {pdr[1], pdr[0]};
    dWEN  = {pdw[1], pdw[0]};
    iaddr = {ia[1], ia[0]};
    daddr = {da[1], da[0]};
    dstore = {ds[1], ds[0]};
  endtask

  task automatic test_random();
    int w, k, nstall;
    logic [31:0] ld, exp_addr;
    logic [1:0]  exp_iw, exp_dw, exp_ccw, exp_cci;
    logic [63:0] exp_il, exp_dl, exp_snp;
    do_reset();
    rr = 0;
    for (int c = 0; c < 2; c++) begin pi[c] = 0; pdr[c] = 0; pdw[c] = 0; end
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pi[c] && $urandom_range(0, 2) == 0) begin pi[c] = 1; ia[c] = $urandom; end
        if (!pdr[c] && !pdw[c]) begin
          case ($urandom_range(0, 3))
            1: pdr[c] = 1;
            2: pdw[c] = 1;
            3: begin pdr[c] = 1; pdw[c] = 1; end
            default: ;
          endcase
          da[c] = $urandom; ds[c] = $urandom;
        end
      end
      if (!(pi[0] | pi[1] | pdr[0] | pdr[1] | pdw[0] | pdw[1])) begin pi[0] = 1; ia[0] = $urandom; end
      // Priority CPU if it asks, otherwise the other one; write > read > fetch.
      w = (pi[rr] | pdr[rr] | pdw[rr]) ? rr : 1 - rr;
      k = pdw[w] ? 0 : (pdr[w] ? 1 : 2);
      exp_addr = (k == 2) ? ia[w] : da[w];
      exp_ccw = 2'b00; exp_snp = 64'h0;
`ifdef MEM_ARBITER_SNOOP_EN
      if (k != 2) begin exp_ccw[1 - w] = 1'b1; exp_snp[(1 - w) * 32 +: 32] = da[w]; end
`endif
      adv(); drive_model(); ccwrite = 2'($urandom); ramstate = 2'($urandom); #2;
      checks++; if ({ramREN, ramWEN} !== 2'b00 || iwait !== 2'b11 || dwait !== 2'b11) begin failures++; $display("FAIL rnd_idle t=%0d got=%b/%b/%b", t, {ramREN, ramWEN}, iwait, dwait); end
      nstall = $urandom_range(0, 3);
      for (int s = 0; s < nstall; s++) begin
        adv();
        case ($urandom_range(0, 2)) 0: ramstate = RS_FREE; 1: ramstate = RS_BUSY; default: ramstate = RS_ERROR; endcase
        ramload = $urandom; #2;
        checks++; if ({ramREN, ramWEN} !== ((k == 0) ? 2'b01 : 2'b10) || ramaddr !== exp_addr) begin failures++; $display("FAIL rnd_stall t=%0d got=%b/%h exp=%0d/%h", t, {ramREN, ramWEN}, ramaddr, k, exp_addr); end
        checks++; if (iwait !== 2'b11 || dwait !== 2'b11 || ccwait !== exp_ccw || ccsnoopaddr !== exp_snp) begin failures++; $display("FAIL rnd_stall_wait t=%0d got=%b/%b/%b", t, iwait, dwait, ccwait); end
      end
      ld = $urandom;
      exp_iw = 2'b11; exp_dw = 2'b11; exp_il = 64'h0; exp_dl = 64'h0; exp_cci = 2'b00;
      if (k == 2) begin exp_iw[w] = 1'b0; exp_il[w * 32 +: 32] = ld; end
      else begin
        exp_dw[w] = 1'b0;
        if (k == 1) exp_dl[w * 32 +: 32] = ld;
      end
      adv(); ramstate = RS_ACCESS; ramload = ld; #2;
`ifdef MEM_ARBITER_SNOOP_EN
      if (k != 2) exp_cci[1 - w] = ccwrite[w] | (k == 0);
`endif
      checks++; if ({ramREN, ramWEN} !== ((k == 0) ? 2'b01 : 2'b10) || ramaddr !== exp_addr) begin failures++; $display("FAIL rnd_done_req t=%0d got=%b/%h exp=%0d/%h", t, {ramREN, ramWEN}, ramaddr, k, exp_addr); end
      if (k == 0) begin
        checks++; if (ramstore !== ds[w]) begin failures++; $display("FAIL rnd_store t=%0d got=%h exp=%h", t, ramstore, ds[w]); end
      end
      checks++; if (iwait !== exp_iw || dwait !== exp_dw) begin failures++; $display("FAIL rnd_waits t=%0d got=%b/%b exp=%b/%b", t, iwait, dwait, exp_iw, exp_dw); end
      checks++; if (iload !== exp_il || dload !== exp_dl) begin failures++; $display("FAIL rnd_loads t=%0d got=%h/%h exp=%h/%h", t, iload, dload, exp_il, exp_dl); end
      checks++; if (ccinv !== exp_cci) begin failures++; $display("FAIL rnd_ccinv t=%0d got=%b exp=%b", t, ccinv, exp_cci); end
      case (k)
        0: pdw[w] = 0;
        1: pdr[w] = 0;
        default: pi[w] = 0;
      endcase
      rr = 1 - w;
    end
    adv(); clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    RST = 1'b1;
    test_reset();
    test_single_fetch();
    test_rr_alternate();
    test_write_then_fetch();
    test_error_retry();
    test_reset_mid();
    test_abort();
    test_snoop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory controller core behind the cache-control interface.
- Shares the single RAM port among up to two CPUs, each issuing instruction-fetch (iREN), data-read (dREN) and data-write (dWEN) requests.
- Sequences every access through a small FSM, returns data and wait handshakes per cache, and round-robins between CPUs so neither starves.

Parameters:
- CPUS, 2, number of cache pairs arbitrated (1 or 2; at 1, CPU 1 inputs are ignored and its outputs are held at reset values).
- WORD_W, 32, width of address and data words (word_t).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  CPUS  instruction read request per CPU.
- dREN  in  CPUS  data read request per CPU.
- dWEN  in  CPUS  data write request per CPU.
- iaddr  in  CPUS*WORD_W  instruction address per CPU.
- daddr  in  CPUS*WORD_W  data address per CPU.
- dstore  in  CPUS*WORD_W  write data per CPU.
- ccwrite  in  CPUS  requester intends exclusive write (coherence).
- iwait  out  CPUS  instruction wait; low only in the completion cycle.
- dwait  out  CPUS  data wait; low only in the completion cycle.
- iload  out  CPUS*WORD_W  instruction return data.
- dload  out  CPUS*WORD_W  data return data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ccwait, ccinv  out  CPUS  coherence outputs (see Optional Feature).
- ccsnoopaddr  out  CPUS*WORD_W  snoop address (see Optional Feature).

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, grant registers cleared.
  - iwait=dwait=all 1; iload=dload=0.
  - ramREN=ramWEN=0; ramaddr=ramstore=0.
  - ccwait=ccinv=0; ccsnoopaddr=0.
- Request kinds and priority:
  - Within one CPU: dWEN > dREN > iREN.
  - Across CPUs: the CPU equal to rr_ptr has priority. If it has no request, the other CPU is chosen.
- FSM states:
  - IDLE: if any request is pending, register winner cpu, kind, addr and store, then go to REQ. Otherwise stay in IDLE. All RAM enables are 0.
  - REQ:
    - Drive ramaddr and ramstore from the registered values. Drive ramREN=1 (read kinds) or ramWEN=1 (write).
    - On ramstate==ACCESS (same-cycle completion):
      - Drop the matching wait low for the winner, combinationally, for exactly that cycle.
      - For reads, drive the matching load = ramload.
      - Set rr_ptr = ~winner, then go to IDLE.
    - On BUSY or FREE: stay in REQ.
    - On ERROR: stay in REQ, keep the request asserted, keep waits high (the access is retried).
    - Abort: if the winner deasserts the granted request bit while in REQ, go to IDLE without completing. rr_ptr is unchanged.
- Latency:
  - Minimum 2 cycles from request to completion (1 cycle in IDLE, completion in the first REQ cycle with ACCESS).
  - A mandatory IDLE cycle follows every completion; this bubble is what gives round-robin fairness.
- Data hold:
  - Loads not being completed are 0.
  - Waits not being completed are 1, including the other kind of the same CPU.
- Simultaneous events:
  - Both CPUs request on the same IDLE cycle: rr_ptr decides the winner.
  - The same CPU requests dWEN and iREN together: the data write completes first. The instruction fetch is re-arbitrated on the next IDLE.
- Reset mid-operation: RST in REQ forces IDLE next cycle and drives all outputs to reset values that cycle. The in-flight access is dropped.
- ramaddr and ramstore are registered values. Enables and waits are combinational from state plus ramstate.

Optional Feature:
- Macro: MEM_ARBITER_SNOOP_EN.
- Defined:
  - While in REQ for a data kind by CPU w, drive ccsnoopaddr[~w] = granted daddr and ccwait[~w] = 1.
  - In the completion cycle, set ccinv[~w] = ccwrite[w] || kind==dWEN.
  - All cc outputs are 0 in IDLE.
- Undefined: ccwait, ccinv and ccsnoopaddr are tied to 0.

Decomposition:
- Add to cpu_types_pkg:
  - memarb_state_t enum (IDLE, REQ).
  - req_kind_t enum (KIND_DWEN, KIND_DREN, KIND_IREN).
  - Reuse the existing word_t and ramstate_t.
- One sub-module, memarb_pick: combinational priority encoder. It takes the request vectors and rr_ptr and returns valid, cpu and kind.

Test Plan:
- CPU0 iREN=1, iaddr=0x100; RAM returns ACCESS on the 2nd REQ cycle with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100; iwait[0]=0 for one cycle with iload[0]=0xDEADBEEF; 3 cycles total.
- Both CPUs dREN at once from reset, addrs 0x200 and 0x300 -> CPU0 is served first, then CPU1. Repeated simultaneous requests alternate 0,1,0,1.
- CPU1 dWEN=1 and iREN=1, dstore=0x12345678, daddr=0x40 -> the write completes first (ramWEN=1, ramstore=0x12345678); the fetch completes after the IDLE bubble.
- ramstate=ERROR for 3 cycles, then ACCESS -> waits stay high throughout; completion occurs once, with no duplicate ramREN completion.
- RST asserted during REQ -> next cycle state=IDLE, all enables 0, all waits 1; a request reissued afterwards completes normally.
- With MEM_ARBITER_SNOOP_EN defined, CPU0 dWEN to 0x80 -> ccwait[1]=1 and ccsnoopaddr[1]=0x80 during REQ; ccinv[1]=1 in the completion cycle.
